cast_gather_arbiter: RTL and testbench

Per-tile packet-level arbiter that shares the single tile-to-NoC injection stream (`cast_gather_*_i` of the NoC top) between the tile's cast producer and gather producer. Grants whole packets in round-robin order, holds the grant until the tail flit is accepted, and keeps per-source packet counters for debug and performance monitoring. Sits between the tile core and the NoC top, one instance per `[x][y]` position.

---
 rtl/cast_gather_arbiter.sv | 130 +++++++++++++
 tb/tb_cast_gather_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cast_gather_arbiter.sv
// cast_gather_arbiter: packet-level round-robin arbiter sharing one tile-to-NoC
// injection stream between the cast and gather producers. A grant is held from
// head to tail, and per-source packet counters are kept for debug.
// Optional feature: define CAST_GATHER_ARB_OUT_REG_EN to register the output
// through a 2-entry skid buffer (1-cycle latency, no ready_i-to-ready_o path).

`ifndef DW
`define DW 32
`endif

module cast_gather_arbiter #(
    parameter int DW = `DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] cast_data_i,
    input  logic          cast_last_i,
    input  logic          cast_valid_i,
    output logic          cast_ready_o,
    input  logic [DW-1:0] gather_data_i,
    input  logic          gather_last_i,
    input  logic          gather_valid_i,
    output logic          gather_ready_o,
    output logic [DW-1:0] cast_gather_data_o,
    output logic          cast_gather_valid_o,
    input  logic          cast_gather_ready_i,
    output logic [CW-1:0] cast_pkt_cnt_o,
    output logic [CW-1:0] gather_pkt_cnt_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, LOCK_C, LOCK_G} state_t;

    state_t        state;
    logic          prio;      // 0 favours cast, 1 favours gather
    logic          grant_c;
    logic          grant_g;
    logic          acc;       // downstream (NoC or skid buffer) can take a flit
    logic [DW-1:0] sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic          fire;

    // Grant selection: round-robin in IDLE, fixed to the owner while locked.
    // Gated by rstn so outputs drop to reset values the moment reset asserts.
    always_comb begin
        grant_c = 1'b0;
        grant_g = 1'b0;
        if (rstn) begin
            case (state)
                IDLE: begin
                    if (cast_valid_i && (!gather_valid_i || !prio))
                        grant_c = 1'b1;
                    else if (gather_valid_i)
                        grant_g = 1'b1;
                end
                LOCK_C:  grant_c = 1'b1;
                LOCK_G:  grant_g = 1'b1;
                default: ;
            endcase
        end
    end

    assign sel_data       = grant_g ? gather_data_i : cast_data_i;
    assign sel_valid      = (grant_c & cast_valid_i) | (grant_g & gather_valid_i);
    assign sel_last       = grant_g ? gather_last_i : cast_last_i;
    assign cast_ready_o   = grant_c & acc;
    assign gather_ready_o = grant_g & acc;
    assign fire           = sel_valid & acc;
    assign busy_o         = (state != IDLE);

    // Packet FSM, round-robin pointer and per-source tail counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            prio             <= 1'b0;
            cast_pkt_cnt_o   <= '0;
            gather_pkt_cnt_o <= '0;
        end else if (fire) begin
            if (sel_last) begin
                state <= IDLE;
                prio  <= grant_c;  // hand priority to the other source
                if (grant_c)
                    cast_pkt_cnt_o <= cast_pkt_cnt_o + CW'(1);
                else
                    gather_pkt_cnt_o <= gather_pkt_cnt_o + CW'(1);
            end else begin
                state <= grant_c ? LOCK_C : LOCK_G;
            end
        end
    end

`ifdef CAST_GATHER_ARB_OUT_REG_EN
    logic [DW-1:0] buf_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          pop;

    // Readies depend only on occupancy; two entries sustain 1 flit/cycle.
    assign acc                 = (cnt != 2'd2);
    assign pop                 = (cnt != 2'd0) && cast_gather_ready_i;
    assign cast_gather_valid_o = (cnt != 2'd0);
    assign cast_gather_data_o  = buf_q[rd_ptr];

    // Skid buffer pointers and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (fire) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, fire} - {1'b0, pop};
        end
    end

    // Skid buffer storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (fire) buf_q[wr_ptr] <= sel_data;
    end
`else
    assign acc                 = cast_gather_ready_i;
    assign cast_gather_valid_o = sel_valid;
    assign cast_gather_data_o  = sel_data;
`endif

endmodule

// File: tb/tb_cast_gather_arbiter.sv
// Directed bench for cast_gather_arbiter (base build, combinational path).
module tb_cast_gather_arbiter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] cast_data_i;
    logic          cast_last_i;
    logic          cast_valid_i;
    logic          cast_ready_o;
    logic [DW-1:0] gather_data_i;
    logic          gather_last_i;
    logic          gather_valid_i;
    logic          gather_ready_o;
    logic [DW-1:0] cast_gather_data_o;
    logic          cast_gather_valid_o;
    logic          cast_gather_ready_i;
    logic [CW-1:0] cast_pkt_cnt_o;
    logic [CW-1:0] gather_pkt_cnt_o;
    logic          busy_o;

    always #5 clk = ~clk;

    cast_gather_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cast_data_i         (cast_data_i),
        .cast_last_i         (cast_last_i),
        .cast_valid_i        (cast_valid_i),
        .cast_ready_o        (cast_ready_o),
        .gather_data_i       (gather_data_i),
        .gather_last_i       (gather_last_i),
        .gather_valid_i      (gather_valid_i),
        .gather_ready_o      (gather_ready_o),
        .cast_gather_data_o  (cast_gather_data_o),
        .cast_gather_valid_o (cast_gather_valid_o),
        .cast_gather_ready_i (cast_gather_ready_i),
        .cast_pkt_cnt_o      (cast_pkt_cnt_o),
        .gather_pkt_cnt_o    (gather_pkt_cnt_o),
        .busy_o              (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Source models: flit k of a cast packet carries C0+k, gather carries A0+k.
    int   c_idx, g_idx, c_len, g_len;
    logic c_en, g_en;
    logic hs_c, hs_g;

    logic [7:0] exp_b [6] = '{8'hC0, 8'hC1, 8'hA0, 8'hA1, 8'hC0, 8'hC1};
    logic [7:0] exp_c [7] = '{8'hA0, 8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA3, 8'hC0};
    logic       rdy_c [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        cast_data_i    = DW'(8'hC0 + c_idx);
        cast_last_i    = (c_idx == c_len - 1);
        cast_valid_i   = c_en;
        gather_data_i  = DW'(8'hA0 + g_idx);
        gather_last_i  = (g_idx == g_len - 1);
        gather_valid_i = g_en;
    endtask

    // Advance one clock: sources step past any flit accepted this cycle.
    task automatic step();
        hs_c = cast_valid_i & cast_ready_o;
        hs_g = gather_valid_i & gather_ready_o;
        @(posedge clk);
        #1;
        if (hs_c) c_idx = (c_idx + 1) % c_len;
        if (hs_g) g_idx = (g_idx + 1) % g_len;
        drive();
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        c_en = 1'b0; g_en = 1'b0;
        c_idx = 0; g_idx = 0; c_len = 1; g_len = 1;
        cast_gather_ready_i = 1'b1;
        drive();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive();
        #2;
    endtask

    initial begin
        // Reset state
        rstn = 1'b0;
        c_en = 1'b0; g_en = 1'b0;
        c_idx = 0; g_idx = 0; c_len = 1; g_len = 1;
        cast_gather_ready_i = 1'b1;
        drive();
        #3;
        chk("rst_valid", 32'(cast_gather_valid_o), 0);
        chk("rst_cready", 32'(cast_ready_o), 0);
        chk("rst_gready", 32'(gather_ready_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ccnt", 32'(cast_pkt_cnt_o), 0);
        chk("rst_gcnt", 32'(gather_pkt_cnt_o), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #2;

        // Cast 3-flit packet alone
        c_len = 3; c_en = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("a_data", 32'(cast_gather_data_o), 32'(8'hC0 + k));
            chk("a_valid", 32'(cast_gather_valid_o), 1);
            chk("a_busy", 32'(busy_o), (k == 0) ? 0 : 1);
            if (k == 2) c_en = 1'b0;
            step();
        end
        chk("a_valid_end", 32'(cast_gather_valid_o), 0);
        chk("a_busy_end", 32'(busy_o), 0);
        chk("a_ccnt", 32'(cast_pkt_cnt_o), 1);

        // Both sources with 2-flit packets from reset
        do_reset();
        c_len = 2; g_len = 2; c_en = 1'b1; g_en = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("b_data", 32'(cast_gather_data_o), 32'(exp_b[k]));
            chk("b_valid", 32'(cast_gather_valid_o), 1);
            if (k == 5) begin c_en = 1'b0; g_en = 1'b0; end
            step();
        end
        chk("b_ccnt", 32'(cast_pkt_cnt_o), 2);
        chk("b_gcnt", 32'(gather_pkt_cnt_o), 1);

        // Gather 4-flit packet with NoC stall, cast head arrives mid-packet
        do_reset();
        g_len = 4; c_len = 2; g_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cast_gather_ready_i = rdy_c[k];
            c_en = (k >= 1);
            drive();
            #1;
            chk("c_data", 32'(cast_gather_data_o), 32'(exp_c[k]));
            chk("c_cready", 32'(cast_ready_o), (k == 6) ? 1 : 0);
            chk("c_gready", 32'(gather_ready_o), (k < 6) ? 32'(rdy_c[k]) : 0);
            step();
        end
        chk("c_gcnt", 32'(gather_pkt_cnt_o), 1);

        // Single-flit packets, strict alternation, FSM stays IDLE
        do_reset();
        c_en = 1'b1; g_en = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("d_data", 32'(cast_gather_data_o), (k % 2 == 0) ? 32'h00C0 : 32'h00A0);
            chk("d_busy", 32'(busy_o), 0);
            if (k == 9) begin c_en = 1'b0; g_en = 1'b0; end
            step();
        end
        chk("d_ccnt", 32'(cast_pkt_cnt_o), 5);
        chk("d_gcnt", 32'(gather_pkt_cnt_o), 5);

        // 17 cast packets wrap a 4-bit counter to 1
        do_reset();
        c_en = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 17; k++) begin
            if (k == 16) c_en = 1'b0;
            step();
        end
        chk("e_ccnt_wrap", 32'(cast_pkt_cnt_o), 1);

        // Reset asserted while flit 2 of 4 of a cast packet is on the output
        do_reset();
        c_len = 4; c_en = 1'b1;
        drive();
        #1;
        step();
        step();
        chk("f_data_mid", 32'(cast_gather_data_o), 32'h00C2);
        chk("f_busy_mid", 32'(busy_o), 1);
        rstn = 1'b0;
        #1;
        chk("f_rst_valid", 32'(cast_gather_valid_o), 0);
        chk("f_rst_cready", 32'(cast_ready_o), 0);
        chk("f_rst_busy", 32'(busy_o), 0);
        c_en = 1'b0; c_idx = 0;
        g_en = 1'b1; g_len = 4; g_idx = 0;
        drive();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("f_g_data", 32'(cast_gather_data_o), 32'h00A0);
        chk("f_g_ready", 32'(gather_ready_o), 1);
        chk("f_c_ready", 32'(cast_ready_o), 0);
        step();
        chk("f_g_busy", 32'(busy_o), 1);
        chk("f_g_data1", 32'(cast_gather_data_o), 32'h00A1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
